axil_tlk_reg_bridge: RTL and testbench
======================================

Name: axil_tlk_reg_bridge

Overview:
AXI4-Lite slave that converts PS register accesses into the single-cycle register-bus strobes consumed by the dual-TLK2711 wrapper: i_reg_wen/waddr/wdata and i_reg_ren/raddr, with read data returned on o_reg_rdata. It sits directly upstream of the wrapper in the ps_clk domain, between the Zynq MPSoC M_AXI_HPM port (via interconnect) and the wrapper.
The block serialises reads and writes, so at most one register-bus access is in flight. It also checks alignment and strobes, and generates AXI responses.

Parameters:
AXI_ADDR_WIDTH, 32, width of s_axil_awaddr/araddr
REG_ADDR_WIDTH, 16, width of register-bus address; must be <= AXI_ADDR_WIDTH
REG_DATA_WIDTH, 64, AXI-Lite and register-bus data width
RD_LATENCY, 2, cycles from o_reg_ren pulse to valid i_reg_rdata; range 1..7

Ports:
ps_clk  in  1  single clock; all logic on rising edge
ps_rst_n  in  1  asynchronous, active-low reset
s_axil_awaddr  in  AXI_ADDR_WIDTH  write address, byte-addressed
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  REG_DATA_WIDTH  write data
s_axil_wstrb  in  REG_DATA_WIDTH/8  write byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  AXI_ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  REG_DATA_WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
o_reg_wen  out  1  one-cycle write strobe to the register bus
o_reg_waddr  out  REG_ADDR_WIDTH  write address (AXI address low bits)
o_reg_wdata  out  REG_DATA_WIDTH  write data
o_reg_ren  out  1  one-cycle read strobe to the register bus
o_reg_raddr  out  REG_ADDR_WIDTH  read address
i_reg_rdata  in  REG_DATA_WIDTH  OR-combined read data from the register-bus slaves

Behaviour:
- Reset (ps_rst_n low, asynchronous): every output is 0; state is IDLE; the arbitration pointer points to write.
- FSM states:
  - IDLE: no access in progress.
  - WR_ACCEPT: waiting for the missing AW or W beat.
  - WR_RESP: write response pending.
  - RD_WAIT: counting RD_LATENCY.
  - RD_RESP: read response pending.
- Ready signals:
  - s_axil_awready and s_axil_wready are high only in IDLE/WR_ACCEPT, and only until their beat has been captured.
  - s_axil_arready is high only in IDLE when read wins arbitration.
  - Handshake = valid & ready on the same edge.
- Arbitration in IDLE:
  - Write request = awvalid | wvalid; read request = arvalid.
  - If both are pending, round-robin: the winner alternates, and the pointer flips after each completed transaction. If only one is pending, it wins.
- Write path:
  - AW and W are captured independently, in either order or together. When both are held, exactly one o_reg_wen pulse is issued on the next cycle with the captured address/data, then the FSM goes to WR_RESP.
  - bvalid rises on the same edge as the wen pulse and holds until bready.
  - Error case: if awaddr[2:0]!=0 or wstrb != all-ones, no wen pulse is issued and bresp=SLVERR; otherwise bresp=OKAY.
- Read path:
  - On AR handshake, o_reg_ren pulses on the next cycle with o_reg_raddr=araddr[REG_ADDR_WIDTH-1:0].
  - A counter loads RD_LATENCY. When it expires, i_reg_rdata is registered into s_axil_rdata and rvalid rises; rvalid holds until rready.
  - Misaligned araddr: no ren pulse, rdata=0, rresp=SLVERR, rvalid one cycle after AR handshake.
- Address bits above REG_ADDR_WIDTH are ignored; address decode is the slaves' job.
- o_reg_waddr/wdata and o_reg_raddr hold their last value between strobes.
- Stalls: bready or rready low stalls the FSM indefinitely; no new AW/W/AR is accepted until the response handshake completes.
- Back-to-back: earliest next accept is the cycle after the B/R handshake. Minimum write = 3 cycles; minimum read = RD_LATENCY+3.
- Reset mid-transaction: all state is dropped; no strobe is issued after ps_rst_n deasserts.

Decomposition:
- Package tlk_reg_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - FSM state enum
  - REG_ADDR_WIDTH/REG_DATA_WIDTH defaults, shared with the register-bus slaves
- No sub-module is needed. The read-latency counter and the AW/W capture registers are inline.

Test Plan:
- Aligned write: AW and W together (addr 0x0108, data 0xDEADBEEF_01234567, wstrb 0xFF) -> single o_reg_wen pulse with waddr 0x0108 and that data; bvalid with OKAY; exactly 1 strobe.
- W beat 3 cycles before AW (addr 0x0010), then bready held low for 5 cycles -> one wen after AW arrives; bvalid held 5+ cycles; arready low throughout.
- Read with RD_LATENCY=2: araddr 0x0100, slave drives 0xA5A5 exactly 2 cycles after ren -> rdata 0xA5A5, OKAY, rvalid at cycle 4 after the AR handshake.
- Errors:
  - awaddr 0x0104 with wstrb 0xFF -> no wen, SLVERR.
  - awaddr 0x0108 with wstrb 0x0F -> no wen, SLVERR.
  - araddr 0x0003 -> no ren, rdata 0, SLVERR.
- Contention: arvalid and awvalid/wvalid held continuously for 4 transactions -> order W,R,W,R; never wen and ren in the same cycle.
- ps_rst_n pulsed low during RD_WAIT -> all outputs 0 immediately; no ren, rvalid or wen afterwards until a new AR handshake.

Source files
------------

// File: rtl/tlk_reg_pkg.sv
// ----------------------------------------------------------------------------
// tlk_reg_pkg
// Shared definitions for the TLK2711 register bus: AXI response codes, the
// bridge FSM state encoding and the default register-bus widths used by the
// bridge and the register-bus slaves.
// ----------------------------------------------------------------------------
package tlk_reg_pkg;

    localparam int TLK_REG_ADDR_WIDTH = 16;
    localparam int TLK_REG_DATA_WIDTH = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_ACCEPT = 3'd1,
        ST_WR_RESP   = 3'd2,
        ST_RD_WAIT   = 3'd3,
        ST_RD_RESP   = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/axil_tlk_reg_bridge.sv
// ----------------------------------------------------------------------------
// axil_tlk_reg_bridge
// AXI4-Lite slave converting PS register accesses into single-cycle register
// bus strobes for the dual-TLK2711 wrapper. One access in flight at a time;
// reads and writes are serialised with a round-robin pointer on contention.
//
// Ports:
//   ps_clk, ps_rst_n        clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*        AXI4-Lite write channels
//   s_axil_ar*/r*           AXI4-Lite read channels
//   o_reg_wen/waddr/wdata   one-cycle register-bus write strobe + payload
//   o_reg_ren/raddr         one-cycle register-bus read strobe + address
//   i_reg_rdata             OR-combined read data, valid RD_LATENCY cycles
//                           after o_reg_ren
// ----------------------------------------------------------------------------
module axil_tlk_reg_bridge
    import tlk_reg_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = TLK_REG_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = TLK_REG_DATA_WIDTH,
    parameter int RD_LATENCY     = 2
)(
    input  logic                        ps_clk,
    input  logic                        ps_rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [REG_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [REG_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [REG_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    output logic                        o_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0]   o_reg_waddr,
    output logic [REG_DATA_WIDTH-1:0]   o_reg_wdata,
    output logic                        o_reg_ren,
    output logic [REG_ADDR_WIDTH-1:0]   o_reg_raddr,
    input  logic [REG_DATA_WIDTH-1:0]   i_reg_rdata
);

    bridge_state_t               r_state, w_state_nxt;
    logic                        r_ptr_wr;      // 1: write wins on contention
    logic                        r_aw_held, r_w_held;
    logic                        r_aw_err, r_w_err;
    logic [REG_ADDR_WIDTH-1:0]   r_awaddr;
    logic [REG_DATA_WIDTH-1:0]   r_wdata;
    logic [2:0]                  r_rd_cnt;

    logic w_awready, w_wready, w_arready, w_issue_wr;
    logic w_wr_win, w_rd_win, w_ar_misalign;
    logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
    logic w_unused_addr;

    // Address bits above the register-bus width are deliberately ignored.
    assign w_unused_addr = ^{s_axil_awaddr, s_axil_araddr};

    assign w_wr_win      = (s_axil_awvalid | s_axil_wvalid) & (~s_axil_arvalid | r_ptr_wr);
    assign w_rd_win      = s_axil_arvalid & ~(s_axil_awvalid | s_axil_wvalid) |
                           s_axil_arvalid & ~r_ptr_wr;
    assign w_ar_misalign = |s_axil_araddr[2:0];

    // Readies are combinational from state; gate with reset so they read 0
    // while reset is asserted even if a master is already presenting valid.
    assign s_axil_awready = w_awready & ps_rst_n;
    assign s_axil_wready  = w_wready  & ps_rst_n;
    assign s_axil_arready = w_arready & ps_rst_n;

    assign w_aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_w_hs  = s_axil_wvalid  & s_axil_wready;
    assign w_ar_hs = s_axil_arvalid & s_axil_arready;
    assign w_b_hs  = s_axil_bvalid  & s_axil_bready;
    assign w_r_hs  = s_axil_rvalid  & s_axil_rready;

    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_awready   = 1'b0;
        w_wready    = 1'b0;
        w_arready   = 1'b0;
        w_issue_wr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_win) begin
                    w_awready   = 1'b1;
                    w_wready    = 1'b1;
                    w_state_nxt = ST_WR_ACCEPT;
                end else if (w_rd_win) begin
                    w_arready   = 1'b1;
                    w_state_nxt = w_ar_misalign ? ST_RD_RESP : ST_RD_WAIT;
                end
            end
            ST_WR_ACCEPT: begin
                if (r_aw_held && r_w_held) begin
                    w_issue_wr  = 1'b1;
                    w_state_nxt = ST_WR_RESP;
                end else begin
                    w_awready = ~r_aw_held;
                    w_wready  = ~r_w_held;
                end
            end
            ST_WR_RESP: if (w_b_hs) w_state_nxt = ST_IDLE;
            ST_RD_WAIT: if (r_rd_cnt == 3'd0) w_state_nxt = ST_RD_RESP;
            ST_RD_RESP: if (w_r_hs) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ps_clk or negedge ps_rst_n) begin
        if (!ps_rst_n) begin
            r_ptr_wr      <= 1'b1;
            r_aw_held     <= 1'b0;
            r_w_held      <= 1'b0;
            r_aw_err      <= 1'b0;
            r_w_err       <= 1'b0;
            r_awaddr      <= '0;
            r_wdata       <= '0;
            r_rd_cnt      <= '0;
            s_axil_bresp  <= RESP_OKAY;
            s_axil_bvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
            s_axil_rvalid <= 1'b0;
            o_reg_wen     <= 1'b0;
            o_reg_waddr   <= '0;
            o_reg_wdata   <= '0;
            o_reg_ren     <= 1'b0;
            o_reg_raddr   <= '0;
        end else begin
            o_reg_wen <= 1'b0;
            o_reg_ren <= 1'b0;

            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axil_awaddr[REG_ADDR_WIDTH-1:0];
                r_aw_err  <= |s_axil_awaddr[2:0];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axil_wdata;
                r_w_err  <= (s_axil_wstrb != '1);
            end

            // Both beats held: strobe (unless faulty) and raise bvalid together.
            if (w_issue_wr) begin
                r_aw_held     <= 1'b0;
                r_w_held      <= 1'b0;
                s_axil_bvalid <= 1'b1;
                if (r_aw_err || r_w_err) begin
                    s_axil_bresp <= RESP_SLVERR;
                end else begin
                    s_axil_bresp <= RESP_OKAY;
                    o_reg_wen    <= 1'b1;
                    o_reg_waddr  <= r_awaddr;
                    o_reg_wdata  <= r_wdata;
                end
            end

            if (w_ar_hs) begin
                if (w_ar_misalign) begin
                    s_axil_rvalid <= 1'b1;
                    s_axil_rresp  <= RESP_SLVERR;
                    s_axil_rdata  <= '0;
                end else begin
                    o_reg_ren   <= 1'b1;
                    o_reg_raddr <= s_axil_araddr[REG_ADDR_WIDTH-1:0];
                    r_rd_cnt    <= 3'(RD_LATENCY);
                end
            end

            // Counter reaches 0 in the cycle the slaves present their data.
            if (r_state == ST_RD_WAIT) begin
                if (r_rd_cnt == 3'd0) begin
                    s_axil_rdata  <= i_reg_rdata;
                    s_axil_rresp  <= RESP_OKAY;
                    s_axil_rvalid <= 1'b1;
                end else begin
                    r_rd_cnt <= r_rd_cnt - 3'd1;
                end
            end

            if (w_b_hs) begin
                s_axil_bvalid <= 1'b0;
                r_ptr_wr      <= ~r_ptr_wr;
            end
            if (w_r_hs) begin
                s_axil_rvalid <= 1'b0;
                r_ptr_wr      <= ~r_ptr_wr;
            end
        end
    end

endmodule

// File: tb/tb_axil_tlk_reg_bridge.sv
module tb_axil_tlk_reg_bridge;
    import tlk_reg_pkg::*;

    localparam int AW = 32;
    localparam int RAW = 16;
    localparam int DW = 64;

    logic            ps_clk = 1'b0;
    logic            ps_rst_n;
    logic [AW-1:0]   s_axil_awaddr;
    logic            s_axil_awvalid;
    logic            s_axil_awready;
    logic [DW-1:0]   s_axil_wdata;
    logic [DW/8-1:0] s_axil_wstrb;
    logic            s_axil_wvalid;
    logic            s_axil_wready;
    logic [1:0]      s_axil_bresp;
    logic            s_axil_bvalid;
    logic            s_axil_bready;
    logic [AW-1:0]   s_axil_araddr;
    logic            s_axil_arvalid;
    logic            s_axil_arready;
    logic [DW-1:0]   s_axil_rdata;
    logic [1:0]      s_axil_rresp;
    logic            s_axil_rvalid;
    logic            s_axil_rready;
    logic            o_reg_wen;
    logic [RAW-1:0]  o_reg_waddr;
    logic [DW-1:0]   o_reg_wdata;
    logic            o_reg_ren;
    logic [RAW-1:0]  o_reg_raddr;
    logic [DW-1:0]   i_reg_rdata;

    axil_tlk_reg_bridge #(
        .AXI_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RAW), .REG_DATA_WIDTH(DW), .RD_LATENCY(2)
    ) dut (
        .ps_clk(ps_clk), .ps_rst_n(ps_rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
        .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata)
    );

    always #5 ps_clk = ~ps_clk;

    int cyc = 0;
    always @(posedge ps_clk) cyc <= cyc + 1;

    // Register-bus slave: data is presented exactly two cycles after ren.
    logic           ren_d1 = 1'b0, ren_d2 = 1'b0;
    logic [RAW-1:0] addr_d1 = '0, addr_d2 = '0;
    always @(posedge ps_clk) begin
        ren_d1  <= o_reg_ren;
        ren_d2  <= ren_d1;
        addr_d1 <= o_reg_raddr;
        addr_d2 <= addr_d1;
    end

    function automatic logic [DW-1:0] slave_data(input logic [RAW-1:0] a);
        if (a == 16'h0100) return 64'h0000_0000_0000_A5A5;
        return {16'hC0DE, 32'h0, a};
    endfunction

    assign i_reg_rdata = ren_d2 ? slave_data(addr_d2) : '0;

    typedef struct { logic [RAW-1:0] addr; logic [DW-1:0] data; } wexp_t;
    typedef struct { logic [DW-1:0] data; logic [1:0] resp; int lat; } rexp_t;

    wexp_t          wq[$];
    logic [RAW-1:0] renq[$];
    logic [1:0]     bq[$];
    rexp_t          rq[$];
    string          order_log = "";

    int errors = 0, checks = 0;
    int n_wen = 0, n_ren = 0, n_rv = 0;
    int ar_cyc = 0;
    logic prev_rvalid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid, s_axil_arready,
                 s_axil_rdata, s_axil_rresp, s_axil_rvalid, o_reg_wen, o_reg_waddr,
                 o_reg_wdata, o_reg_ren, o_reg_raddr};
    endfunction

    // Monitor / scoreboard
    always @(negedge ps_clk) begin : monitor
        wexp_t we;
        rexp_t re;
        logic [RAW-1:0] ra;
        if (ps_rst_n) begin
            if (o_reg_wen || o_reg_ren)
                chk("wen_ren_exclusive", 64'(o_reg_wen & o_reg_ren), 64'd0);
            if (o_reg_wen) begin
                n_wen++;
                if (wq.size() == 0) chk("wen_unexpected", 64'(o_reg_wen), 64'd0);
                else begin
                    we = wq.pop_front();
                    chk("waddr", 64'(o_reg_waddr), 64'(we.addr));
                    chk("wdata", o_reg_wdata, we.data);
                    chk("wen_with_bvalid", 64'(s_axil_bvalid), 64'd1);
                end
            end
            if (o_reg_ren) begin
                n_ren++;
                if (renq.size() == 0) chk("ren_unexpected", 64'(o_reg_ren), 64'd0);
                else begin
                    ra = renq.pop_front();
                    chk("raddr", 64'(o_reg_raddr), 64'(ra));
                end
            end
            if (s_axil_arvalid && s_axil_arready) ar_cyc = cyc;
            if (s_axil_rvalid && !prev_rvalid) begin
                n_rv++;
                if (rq.size() != 0) chk("r_latency", 64'(cyc - ar_cyc), 64'(rq[0].lat));
            end
            prev_rvalid = s_axil_rvalid;
            if (s_axil_bvalid && s_axil_bready) begin
                if (bq.size() == 0) chk("b_unexpected", 64'(s_axil_bvalid), 64'd0);
                else begin
                    chk("bresp", 64'(s_axil_bresp), 64'(bq.pop_front()));
                    order_log = {order_log, "W"};
                end
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (rq.size() == 0) chk("r_unexpected", 64'(s_axil_rvalid), 64'd0);
                else begin
                    re = rq.pop_front();
                    chk("rdata", s_axil_rdata, re.data);
                    chk("rresp", 64'(s_axil_rresp), 64'(re.resp));
                    order_log = {order_log, "R"};
                end
            end
        end else begin
            prev_rvalid = 1'b0;
        end
    end

    task automatic timeout_fail(input string name);
        errors++;
        checks++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic do_aw(input logic [AW-1:0] a);
        bit done = 0;
        s_axil_awaddr  = a;
        s_axil_awvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge ps_clk);
            if (s_axil_awready) begin
                @(posedge ps_clk);
                #1;
                done = 1;
            end
        end
        s_axil_awvalid = 1'b0;
        if (!done) timeout_fail("aw_timeout");
    endtask

    task automatic do_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        bit done = 0;
        s_axil_wdata  = d;
        s_axil_wstrb  = s;
        s_axil_wvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge ps_clk);
            if (s_axil_wready) begin
                @(posedge ps_clk);
                #1;
                done = 1;
            end
        end
        s_axil_wvalid = 1'b0;
        if (!done) timeout_fail("w_timeout");
    endtask

    task automatic do_ar(input logic [AW-1:0] a);
        bit done = 0;
        s_axil_araddr  = a;
        s_axil_arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge ps_clk);
            if (s_axil_arready) begin
                @(posedge ps_clk);
                #1;
                done = 1;
            end
        end
        s_axil_arvalid = 1'b0;
        if (!done) timeout_fail("ar_timeout");
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] s);
        fork
            do_aw(a);
            do_w(d, s);
        join
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (wq.size() == 0 && renq.size() == 0 && bq.size() == 0 && rq.size() == 0) done = 1;
            else @(posedge ps_clk);
        end
        if (!done) timeout_fail("drain_timeout");
        repeat (2) @(posedge ps_clk);
        #1;
    endtask

    task automatic pulse_reset();
        ps_rst_n = 1'b0;
        repeat (2) @(posedge ps_clk);
        #1;
        ps_rst_n = 1'b1;
        repeat (2) @(posedge ps_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int b_wen, b_ren, b_rv;
        ps_rst_n = 1'b0;
        s_axil_awaddr = '0; s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_araddr = '0;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b1;
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;
        repeat (3) @(posedge ps_clk);
        #1;
        chk("reset_outputs", 64'(any_out()), 64'd0);
        s_axil_awvalid = 1'b0;
        s_axil_arvalid = 1'b0;
        ps_rst_n = 1'b1;
        repeat (2) @(posedge ps_clk);
        #1;

        // Aligned write, AW and W together
        b_wen = n_wen;
        wq.push_back('{addr: 16'h0108, data: 64'hDEADBEEF_01234567});
        bq.push_back(RESP_OKAY);
        do_write(32'h0000_0108, 64'hDEADBEEF_01234567, 8'hFF);
        wait_done();
        chk("t1_wen_count", 64'(n_wen - b_wen), 64'd1);

        // W three cycles before AW, B stalled, a read waiting behind it
        s_axil_bready = 1'b0;
        wq.push_back('{addr: 16'h0010, data: 64'h1111_2222_3333_4444});
        bq.push_back(RESP_OKAY);
        do_w(64'h1111_2222_3333_4444, 8'hFF);
        s_axil_araddr  = 32'h0000_0200;
        s_axil_arvalid = 1'b1;
        repeat (3) @(posedge ps_clk);
        #1;
        do_aw(32'h0000_0010);
        begin : wait_b
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge ps_clk);
                if (s_axil_bvalid) seen = 1;
            end
            if (!seen) timeout_fail("t2_bvalid_timeout");
        end
        for (int k = 0; k < 5; k++) begin
            chk("t2_bvalid_hold", 64'(s_axil_bvalid), 64'd1);
            chk("t2_arready_low", 64'(s_axil_arready), 64'd0);
            @(negedge ps_clk);
        end
        renq.push_back(16'h0200);
        rq.push_back('{data: 64'hC0DE_0000_0000_0200, resp: RESP_OKAY, lat: 4});
        s_axil_bready = 1'b1;
        do_ar(32'h0000_0200);
        wait_done();

        // Aligned read with two-cycle slave latency
        renq.push_back(16'h0100);
        rq.push_back('{data: 64'h0000_0000_0000_A5A5, resp: RESP_OKAY, lat: 4});
        do_ar(32'h0000_0100);
        wait_done();

        // Error cases: no strobes, SLVERR responses
        b_wen = n_wen;
        b_ren = n_ren;
        bq.push_back(RESP_SLVERR);
        do_write(32'h0000_0104, 64'h0123_4567_89AB_CDEF, 8'hFF);
        wait_done();
        bq.push_back(RESP_SLVERR);
        do_write(32'h0000_0108, 64'hFEDC_BA98_7654_3210, 8'h0F);
        wait_done();
        rq.push_back('{data: 64'h0, resp: RESP_SLVERR, lat: 1});
        do_ar(32'h0000_0003);
        wait_done();
        chk("err_no_wen", 64'(n_wen - b_wen), 64'd0);
        chk("err_no_ren", 64'(n_ren - b_ren), 64'd0);

        // Contention: write and read requests held continuously
        pulse_reset();
        order_log = "";
        wq.push_back('{addr: 16'h0020, data: 64'hAAAA_0000_0000_0020});
        wq.push_back('{addr: 16'h0028, data: 64'hBBBB_0000_0000_0028});
        renq.push_back(16'h0300);
        renq.push_back(16'h0308);
        bq.push_back(RESP_OKAY);
        bq.push_back(RESP_OKAY);
        rq.push_back('{data: 64'hC0DE_0000_0000_0300, resp: RESP_OKAY, lat: 4});
        rq.push_back('{data: 64'hC0DE_0000_0000_0308, resp: RESP_OKAY, lat: 4});
        fork
            begin
                do_write(32'h0000_0020, 64'hAAAA_0000_0000_0020, 8'hFF);
                do_write(32'h0000_0028, 64'hBBBB_0000_0000_0028, 8'hFF);
            end
            begin
                do_ar(32'h0000_0300);
                do_ar(32'h0000_0308);
            end
        join
        wait_done();
        checks++;
        if (order_log != "WRWR") begin
            errors++;
            $display("FAIL contention_order: got %s expected WRWR", order_log);
        end

        // Reset during RD_WAIT
        renq.push_back(16'h0100);
        do_ar(32'h0000_0100);
        @(posedge ps_clk);
        #2;
        ps_rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 64'(any_out()), 64'd0);
        b_wen = n_wen;
        b_ren = n_ren;
        b_rv  = n_rv;
        repeat (2) @(posedge ps_clk);
        #1;
        ps_rst_n = 1'b1;
        repeat (12) @(posedge ps_clk);
        #1;
        chk("midrst_no_wen", 64'(n_wen - b_wen), 64'd0);
        chk("midrst_no_ren", 64'(n_ren - b_ren), 64'd0);
        chk("midrst_no_rvalid", 64'(n_rv - b_rv), 64'd0);
        chk("midrst_queues", 64'(renq.size() + rq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
